// File: rtl/sat_result_checker.sv
// Independent SAT result checker: stores the CNF clause set, then re-evaluates
// every stored clause against the solver's returned model and reports a verdict.
module sat_result_checker #(
    parameter int NUM_VARS    = 8,
    parameter int MAX_CLAUSES = 16,
    parameter int IDX_W       = $clog2(MAX_CLAUSES + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clause_valid,
    input  logic [NUM_VARS-1:0] clause_pos,
    input  logic [NUM_VARS-1:0] clause_neg,
    input  logic                clause_last,
    output logic                clause_ready,
    input  logic                solver_ended,
    input  logic                solver_sat,
    input  logic [NUM_VARS-1:0] solver_model,
    output logic                done,
    output logic                pass,
    output logic                unsat_reported,
    output logic [IDX_W-1:0]    fail_idx,
    output logic                overflow
);
    localparam int AW = (MAX_CLAUSES > 1) ? $clog2(MAX_CLAUSES) : 1;
    localparam logic [IDX_W-1:0] MAX_C = IDX_W'(MAX_CLAUSES);

    typedef enum logic [1:0] {LOAD, WAIT_RESULT, CHECK, DONE} state_t;
    state_t state, state_next;

    logic [NUM_VARS-1:0] mem_pos [MAX_CLAUSES];
    logic [NUM_VARS-1:0] mem_neg [MAX_CLAUSES];
    logic [IDX_W-1:0]    count, idx;
    logic [NUM_VARS-1:0] model_q;
    logic                claim_sat;

    logic accept, store, drop, latch, idx_inc;
    logic done_set, pass_val, unsat_set, fail_set;
    logic clause_sat;

    assign clause_ready = (state == LOAD);
    assign accept       = clause_valid && clause_ready;
    // Empty clause reduces to 0 here; a +v/-v pair always yields 1.
    assign clause_sat   = |((mem_pos[idx[AW-1:0]] & model_q) |
                            (mem_neg[idx[AW-1:0]] & ~model_q));

    always_ff @(posedge clock) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        store      = 1'b0;
        drop       = 1'b0;
        latch      = 1'b0;
        idx_inc    = 1'b0;
        done_set   = 1'b0;
        pass_val   = 1'b0;
        unsat_set  = 1'b0;
        fail_set   = 1'b0;
        case (state)
            LOAD: begin
                if (accept) begin
                    if (count < MAX_C) store = 1'b1;
                    else               drop  = 1'b1;
                    if (clause_last) state_next = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                // UNSAT claims also pass through CHECK so every verdict
                // lands at least one edge after the result is sampled.
                if (solver_ended) begin
                    latch      = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = DONE;
                done_set   = 1'b1;
                if (!claim_sat) begin
                    unsat_set = 1'b1;
                end else if (count == '0) begin
                    pass_val = ~overflow;
                end else if (!clause_sat) begin
                    fail_set = 1'b1;
                end else if (idx == count - IDX_W'(1)) begin
                    pass_val = ~overflow;
                end else begin
                    state_next = CHECK;
                    done_set   = 1'b0;
                    idx_inc    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count          <= '0;
            idx            <= '0;
            model_q        <= '0;
            claim_sat      <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            unsat_reported <= 1'b0;
            fail_idx       <= '0;
            overflow       <= 1'b0;
        end else begin
            if (store) count <= count + IDX_W'(1);
            if (drop)  overflow <= 1'b1;
            if (latch) begin
                model_q   <= solver_model;
                claim_sat <= solver_sat;
                idx       <= '0;
            end
            if (idx_inc) idx <= idx + IDX_W'(1);
            if (done_set) begin
                done           <= 1'b1;
                pass           <= pass_val;
                unsat_reported <= unsat_set;
                if (fail_set) fail_idx <= idx;
            end
        end
    end

    // Clause storage needs no reset; count gates every read.
    always_ff @(posedge clock) begin
        if (store) begin
            mem_pos[count[AW-1:0]] <= clause_pos;
            mem_neg[count[AW-1:0]] <= clause_neg;
        end
    end
endmodule

// File: tb/tb_sat_result_checker.sv
// Randomized bench for sat_result_checker against a clause-list reference model.
module tb_sat_result_checker;
    localparam int NV = 8;
    localparam int MC = 16;
    localparam int IW = $clog2(MC + 1);

    logic          clock, reset;
    logic          clause_valid, clause_last, clause_ready;
    logic [NV-1:0] clause_pos, clause_neg;
    logic          solver_ended, solver_sat;
    logic [NV-1:0] solver_model;
    logic          done, pass, unsat_reported, overflow;
    logic [IW-1:0] fail_idx;

    int errs   = 0;
    int checks = 0;

    logic [NV-1:0] cp [20];
    logic [NV-1:0] cn [20];

    sat_result_checker #(.NUM_VARS(NV), .MAX_CLAUSES(MC)) dut (
        .clock(clock), .reset(reset),
        .clause_valid(clause_valid), .clause_pos(clause_pos),
        .clause_neg(clause_neg), .clause_last(clause_last),
        .clause_ready(clause_ready),
        .solver_ended(solver_ended), .solver_sat(solver_sat),
        .solver_model(solver_model),
        .done(done), .pass(pass), .unsat_reported(unsat_reported),
        .fail_idx(fail_idx), .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Literal-level evaluation of one clause against a model.
    function automatic bit clause_true(input int k, input logic [NV-1:0] m);
        for (int v = 0; v < NV; v++)
            if ((cp[k][v] && m[v]) || (cn[k][v] && !m[v])) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        reset        = 1'b1;
        clause_valid = 1'b0;
        clause_last  = 1'b0;
        solver_ended = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                clause_valid = 1'b0;
                clause_pos   = NV'($urandom);
                clause_neg   = NV'($urandom);
                clause_last  = 1'b1;
                tick();
            end
            clause_valid = 1'b1;
            clause_pos   = cp[i];
            clause_neg   = cn[i];
            clause_last  = (i == n - 1);
            tick();
        end
        clause_valid = 1'b0;
        clause_last  = 1'b0;
    endtask

    task automatic run_case(input string tag, input int n, input logic sat,
                            input logic [NV-1:0] model);
        int nst, f, lat, e_pass, e_unsat, e_fail, c;
        bit ovf;
        load(n);
        nst = (n > MC) ? MC : n;
        ovf = (n > MC);
        chk({tag, ".ovf_load"}, int'(overflow), int'(ovf));
        chk({tag, ".ready_off"}, int'(clause_ready), 0);
        repeat ($urandom_range(0, 2)) tick();

        f = -1;
        for (int k = 0; k < nst; k++)
            if (f < 0 && !clause_true(k, model)) f = k;
        e_unsat = 0; e_fail = 0; e_pass = 0;
        if (!sat) begin
            lat = 1; e_unsat = 1;
        end else if (nst == 0) begin
            lat = 1; e_pass = !ovf;
        end else if (f >= 0) begin
            lat = f + 1; e_fail = f;
        end else begin
            lat = nst; e_pass = !ovf;
        end

        solver_ended = 1'b1;
        solver_sat   = sat;
        solver_model = model;
        tick();
        chk({tag, ".done_e0"}, int'(done), 0);
        // Model must already be latched; disturb the solver inputs.
        solver_ended = 1'($urandom);
        solver_sat   = 1'($urandom);
        solver_model = NV'($urandom);
        c = 0;
        while (!done && c < 40) begin
            tick();
            c++;
        end
        chk({tag, ".latency"}, c, lat);
        chk({tag, ".pass"}, int'(pass), e_pass);
        chk({tag, ".unsat"}, int'(unsat_reported), e_unsat);
        chk({tag, ".fail_idx"}, int'(fail_idx), e_fail);
        chk({tag, ".ovf"}, int'(overflow), int'(ovf));

        clause_valid = 1'b1;
        clause_last  = 1'b1;
        solver_ended = 1'b1;
        solver_sat   = ~sat;
        repeat (2) tick();
        clause_valid = 1'b0;
        clause_last  = 1'b0;
        chk({tag, ".hold_done"}, int'(done), 1);
        chk({tag, ".hold_pass"}, int'(pass), e_pass);
        chk({tag, ".hold_ready"}, int'(clause_ready), 0);
    endtask

    initial begin
        logic [NV-1:0] m;
        int n;
        clause_pos = '0; clause_neg = '0; solver_sat = 1'b0; solver_model = '0;
        do_reset();
        chk("rst.done", int'(done), 0);
        chk("rst.pass", int'(pass), 0);
        chk("rst.unsat", int'(unsat_reported), 0);
        chk("rst.fail_idx", int'(fail_idx), 0);
        chk("rst.ovf", int'(overflow), 0);
        chk("rst.ready", int'(clause_ready), 1);

        // (+1 -2), (+2 +3), (-1 +3)
        cp[0] = 8'b001; cn[0] = 8'b010;
        cp[1] = 8'b110; cn[1] = 8'b000;
        cp[2] = 8'b100; cn[2] = 8'b001;
        run_case("plan_sat", 3, 1'b1, 8'b101);
        do_reset();
        run_case("plan_fail", 3, 1'b1, 8'b001);
        do_reset();

        cp[0] = '0; cn[0] = '0;
        cp[1] = 8'hFF; cn[1] = 8'h00;
        run_case("empty0", 2, 1'b1, NV'($urandom));
        do_reset();

        cp[0] = 8'b001; cn[0] = 8'b000;
        run_case("unsat", 1, 1'b0, 8'h00);
        do_reset();

        for (int i = 0; i < 17; i++) begin
            cp[i] = NV'($urandom) | 8'h01; cn[i] = NV'($urandom);
        end
        run_case("ovf17", 17, 1'b1, 8'hFF);
        do_reset();

        // Reset mid-CHECK, with a beat presented during reset.
        for (int i = 0; i < 16; i++) begin cp[i] = 8'hFF; cn[i] = 8'h00; end
        load(16);
        solver_ended = 1'b1; solver_sat = 1'b1; solver_model = 8'hFF;
        repeat (4) tick();
        reset = 1'b1; clause_valid = 1'b1; clause_last = 1'b1; clause_pos = 8'h01;
        tick();
        reset = 1'b0; clause_valid = 1'b0; clause_last = 1'b0; solver_ended = 1'b0;
        chk("midchk.done", int'(done), 0);
        chk("midchk.ready", int'(clause_ready), 1);
        reset = 1'b1; clause_valid = 1'b1; clause_last = 1'b1;
        tick();
        reset = 1'b0; clause_valid = 1'b0; clause_last = 1'b0;
        tick();
        chk("rstload.ready", int'(clause_ready), 1);
        cp[0] = 8'h01; cn[0] = 8'h00;
        run_case("reload1", 1, 1'b1, 8'h01);
        do_reset();

        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(1, 18);
            m = NV'($urandom);
            for (int i = 0; i < n; i++) begin
                cp[i] = NV'($urandom) & NV'($urandom) & NV'($urandom);
                cn[i] = NV'($urandom) & NV'($urandom) & NV'($urandom);
                if ($urandom_range(0, 19) == 0) begin cp[i] = '0; cn[i] = '0; end
            end
            run_case($sformatf("rnd%0d", t), n, ($urandom_range(0, 7) != 0), m);
            do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
